// File: rtl/axis_pkt_gen.sv
// rtl/axis_pkt_gen.sv - AXI4-Stream packet source with programmable length, count and gap
// Emits incrementing-word packets with OPED-style TUSER {dpt, spt, len}.
module axis_pkt_gen #(
  parameter logic [7:0] SPT       = 8'h00,
  parameter int         MAX_GAP_W = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [15:0]          PKT_LEN,
  input  logic [15:0]          PKT_COUNT,
  input  logic [7:0]           DPT,
  input  logic [MAX_GAP_W-1:0] GAP,
  input  logic [31:0]          SEED,
  output logic [31:0]          M_AXIS_DAT_TDATA,
  output logic                 M_AXIS_DAT_TVALID,
  output logic [3:0]           M_AXIS_DAT_TSTRB,
  output logic [127:0]         M_AXIS_DAT_TUSER,
  output logic                 M_AXIS_DAT_TLAST,
  input  logic                 M_AXIS_DAT_TREADY,
  output logic                 BUSY,
  output logic [15:0]          PKTS_SENT
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_GAP = 2'd2} state_t;

  state_t               state_q, state_nxt;
  logic [15:0]          len_q, len_nxt;
  logic [15:0]          cnt_q, cnt_nxt;
  logic [15:0]          pkts_q, pkts_nxt;
  logic [MAX_GAP_W-1:0] gap_q, gap_nxt;
  logic [MAX_GAP_W-1:0] gap_left_q, gap_left_nxt;
  logic [14:0]          words_q, words_nxt;
  logic [14:0]          beat_q, beat_nxt;
  logic [31:0]          word_q, word_nxt;
  logic                 stop_q, stop_nxt;
  logic                 tvalid_q, tvalid_nxt;
  logic                 tlast_q, tlast_nxt;
  logic [3:0]           tstrb_q, tstrb_nxt;
  logic [31:0]          tuser_q, tuser_nxt;
  logic                 busy_q, busy_nxt;

  logic [14:0] words_in;
  logic        start_ok;
  logic        hs;
  logic        last_beat;
  logic        run_done;
  logic        stop_eff;

  // beat_q counts beats remaining in the current packet, including the one on the bus
  assign words_in  = 15'(({1'b0, PKT_LEN} + 17'd3) >> 2);
  assign start_ok  = START && (PKT_LEN != 16'd0);
  assign hs        = tvalid_q && M_AXIS_DAT_TREADY;
  assign last_beat = (beat_q == 15'd1);
  assign run_done  = (cnt_q != 16'd0) && ((pkts_q + 16'd1) == cnt_q);
  assign stop_eff  = stop_q || STOP;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      pkts_q     <= '0;
      gap_q      <= '0;
      gap_left_q <= '0;
      words_q    <= '0;
      beat_q     <= '0;
      word_q     <= '0;
      stop_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tstrb_q    <= '0;
      tuser_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      len_q      <= len_nxt;
      cnt_q      <= cnt_nxt;
      pkts_q     <= pkts_nxt;
      gap_q      <= gap_nxt;
      gap_left_q <= gap_left_nxt;
      words_q    <= words_nxt;
      beat_q     <= beat_nxt;
      word_q     <= word_nxt;
      stop_q     <= stop_nxt;
      tvalid_q   <= tvalid_nxt;
      tlast_q    <= tlast_nxt;
      tstrb_q    <= tstrb_nxt;
      tuser_q    <= tuser_nxt;
      busy_q     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (hs && last_beat) begin
          if (run_done || stop_eff) state_nxt = S_IDLE;
          else if (gap_q == '0)     state_nxt = S_DATA;
          else                      state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (stop_eff)                             state_nxt = S_IDLE;
        else if (gap_left_q == MAX_GAP_W'(1))     state_nxt = S_DATA;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so every port comes straight off a flop
  always_comb begin
    len_nxt      = len_q;
    cnt_nxt      = cnt_q;
    pkts_nxt     = pkts_q;
    gap_nxt      = gap_q;
    gap_left_nxt = gap_left_q;
    words_nxt    = words_q;
    beat_nxt     = beat_q;
    word_nxt     = word_q;
    stop_nxt     = stop_q;
    tuser_nxt    = tuser_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          len_nxt   = PKT_LEN;
          cnt_nxt   = PKT_COUNT;
          gap_nxt   = GAP;
          words_nxt = words_in;
          beat_nxt  = words_in;
          word_nxt  = SEED;
          pkts_nxt  = '0;
          tuser_nxt = {DPT, SPT, PKT_LEN};
        end
      end
      S_DATA: begin
        if (STOP) stop_nxt = 1'b1;
        if (hs) begin
          word_nxt = word_q + 32'd1;
          if (last_beat) begin
            pkts_nxt     = pkts_q + 16'd1;
            beat_nxt     = words_q;
            gap_left_nxt = gap_q;
          end else begin
            beat_nxt = beat_q - 15'd1;
          end
        end
      end
      S_GAP: begin
        if (STOP) stop_nxt = 1'b1;
        gap_left_nxt = gap_left_q - MAX_GAP_W'(1);
      end
      default: ;
    endcase
    if (state_nxt == S_IDLE) stop_nxt = 1'b0;

    busy_nxt   = (state_nxt != S_IDLE);
    tvalid_nxt = (state_nxt == S_DATA);
    tlast_nxt  = tvalid_nxt && (beat_nxt == 15'd1);
    tstrb_nxt  = 4'h0;
    if (tvalid_nxt) begin
      if (tlast_nxt) begin
        case (len_nxt[1:0])
          2'd1:    tstrb_nxt = 4'h1;
          2'd2:    tstrb_nxt = 4'h3;
          2'd3:    tstrb_nxt = 4'h7;
          default: tstrb_nxt = 4'hF;
        endcase
      end else begin
        tstrb_nxt = 4'hF;
      end
    end
  end

  assign M_AXIS_DAT_TDATA  = word_q;
  assign M_AXIS_DAT_TVALID = tvalid_q;
  assign M_AXIS_DAT_TSTRB  = tstrb_q;
  assign M_AXIS_DAT_TLAST  = tlast_q;
  assign M_AXIS_DAT_TUSER  = {96'h0, tuser_q};
  assign BUSY              = busy_q;
  assign PKTS_SENT         = pkts_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb/tb_axis_pkt_gen.sv - scoreboard bench for axis_pkt_gen
`timescale 1ns/1ps
module tb_axis_pkt_gen;

  localparam logic [7:0] SPT_V = 8'h3C;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         START = 1'b0;
  logic         STOP = 1'b0;
  logic [15:0]  PKT_LEN = '0;
  logic [15:0]  PKT_COUNT = '0;
  logic [7:0]   DPT = '0;
  logic [7:0]   GAP = '0;
  logic [31:0]  SEED = '0;
  logic [31:0]  TDATA;
  logic         TVALID;
  logic [3:0]   TSTRB;
  logic [127:0] TUSER;
  logic         TLAST;
  logic         TREADY = 1'b1;
  logic         BUSY;
  logic [15:0]  PKTS_SENT;

  axis_pkt_gen #(.SPT(SPT_V), .MAX_GAP_W(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .STOP(STOP),
    .PKT_LEN(PKT_LEN), .PKT_COUNT(PKT_COUNT), .DPT(DPT), .GAP(GAP), .SEED(SEED),
    .M_AXIS_DAT_TDATA(TDATA), .M_AXIS_DAT_TVALID(TVALID), .M_AXIS_DAT_TSTRB(TSTRB),
    .M_AXIS_DAT_TUSER(TUSER), .M_AXIS_DAT_TLAST(TLAST), .M_AXIS_DAT_TREADY(TREADY),
    .BUSY(BUSY), .PKTS_SENT(PKTS_SENT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0]  data;
    logic [3:0]   strb;
    logic         last;
    logic [127:0] tuser;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        mon_e;
  int           errors = 0;
  int           checks = 0;
  int           ready_pct = 100;
  int           exp_gap = 0;
  int           pkts_seen = 0;
  bit           gap_counting = 0;
  int           gap_idle = 0;
  bit           stall_prev = 0;
  logic [164:0] prev_snap = '0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: packet p, word b carries seed + p*words + b; tail strobe covers len%4 bytes
  task automatic push_run(input logic [15:0] len, input int npkts, input logic [31:0] seed,
                          input logic [7:0] dpt);
    int          words;
    int          tail;
    logic [31:0] w;
    beat_t       e;
    words = (int'(len) + 3) / 4;
    tail  = int'(len) % 4;
    w     = seed;
    for (int p = 0; p < npkts; p++) begin
      for (int b = 0; b < words; b++) begin
        e.data  = w;
        w       = w + 32'd1;
        e.last  = (b == words - 1);
        e.strb  = (e.last && tail != 0) ? 4'((1 << tail) - 1) : 4'hF;
        e.tuser = {96'h0, dpt, SPT_V, len};
        exp_q.push_back(e);
      end
    end
  endtask

  always @(posedge ACLK) begin
    #1;
    TREADY = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
  end

  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (stall_prev)
        chk("stall_hold", {TVALID, TDATA, TSTRB, TLAST, TUSER}, {1'b1, prev_snap});
      if (!BUSY) gap_counting = 0;
      else if (gap_counting) begin
        if (!TVALID) gap_idle++;
        else begin
          chk("gap_len", 192'(gap_idle), 192'(exp_gap));
          gap_counting = 0;
        end
      end
      if (TVALID && TREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h expected no beat", TDATA);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat", {TDATA, TSTRB, TLAST, TUSER}, {mon_e.data, mon_e.strb, mon_e.last, mon_e.tuser});
        end
        if (TLAST) begin
          pkts_seen++;
          gap_counting = 1;
          gap_idle = 0;
        end
      end
      stall_prev = TVALID && !TREADY;
      prev_snap  = {TDATA, TSTRB, TLAST, TUSER};
    end else begin
      stall_prev   = 0;
      gap_counting = 0;
    end
  end

  task automatic start_run(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap,
                           input logic [7:0] dpt, input logic [31:0] seed, input int npkts,
                           input bit with_stop);
    exp_gap   = int'(gap);
    pkts_seen = 0;
    push_run(len, npkts, seed, dpt);
    @(posedge ACLK); #1;
    PKT_LEN = len; PKT_COUNT = cnt; GAP = gap; DPT = dpt; SEED = seed;
    START = 1'b1; STOP = with_stop;
    @(posedge ACLK); #1;
    START = 1'b0; STOP = 1'b0;
    @(negedge ACLK);
    chk("start_resp", {BUSY, TVALID, PKTS_SENT}, {1'b1, 1'b1, 16'd0});
  endtask

  task automatic wait_idle(input int exp_pkts);
    int n;
    n = 0;
    while (BUSY && n < 5000) begin
      @(negedge ACLK);
      n++;
    end
    @(negedge ACLK);
    chk("run_end", {BUSY, TVALID, PKTS_SENT, 32'(exp_q.size())}, {1'b0, 1'b0, 16'(exp_pkts), 32'd0});
    exp_q.delete();
  endtask

  task automatic wait_pkts(input int n);
    int k;
    k = 0;
    while (pkts_seen < n && k < 3000) begin
      @(negedge ACLK);
      k++;
    end
    chk("pkt_wait", 192'(pkts_seen >= n), 192'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rl;
    logic [15:0] rc;
    logic [7:0]  rg;
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_state", {TVALID, TLAST, TDATA, TSTRB, TUSER, BUSY, PKTS_SENT}, '0);
    @(posedge ACLK); #1 ARESETN = 1'b1;

    ready_pct = 100;
    start_run(16'd16, 16'd2, 8'd0, 8'h05, 32'h100, 2, 0);
    wait_idle(2);
    start_run(16'd7, 16'd1, 8'd0, 8'h11, 32'h2000, 1, 0);
    wait_idle(1);
    start_run(16'd1, 16'd1, 8'd0, 8'h22, 32'h3000, 1, 0);
    wait_idle(1);
    start_run(16'd5, 16'd2, 8'd1, 8'h33, 32'h4000, 2, 1);
    wait_idle(2);

    // backpressure, plus a START that must be ignored mid-run
    ready_pct = 50;
    start_run(16'd64, 16'd3, 8'd2, 8'h44, 32'h5000, 3, 0);
    repeat (10) @(posedge ACLK);
    #1 PKT_LEN = 16'd8; SEED = 32'hDEAD; START = 1'b1;
    @(posedge ACLK); #1 START = 1'b0;
    wait_idle(3);

    // STOP mid packet 2 with GAP=3, unlimited count
    ready_pct = 100;
    start_run(16'd32, 16'd0, 8'd3, 8'h55, 32'h6000, 2, 0);
    wait_pkts(1);
    repeat (5) @(posedge ACLK);
    #1 STOP = 1'b1;
    @(posedge ACLK); #1 STOP = 1'b0;
    wait_idle(2);

    // STOP inside the gap
    start_run(16'd8, 16'd0, 8'd5, 8'h66, 32'h7000, 1, 0);
    wait_pkts(1);
    @(posedge ACLK); #1 STOP = 1'b1;
    @(posedge ACLK); #1 STOP = 1'b0;
    wait_idle(1);

    // reset mid-packet, then restart from SEED
    start_run(16'd64, 16'd2, 8'd0, 8'h77, 32'h8000, 2, 0);
    repeat (6) @(posedge ACLK);
    #1 ARESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_mid", {TVALID, TLAST, TDATA, TSTRB, TUSER, BUSY, PKTS_SENT}, '0);
    exp_q.delete();
    @(posedge ACLK); #1 ARESETN = 1'b1;
    start_run(16'd64, 16'd2, 8'd0, 8'h77, 32'h8000, 2, 0);
    wait_idle(2);

    // START with PKT_LEN=0 is ignored
    @(posedge ACLK); #1 PKT_LEN = 16'd0; SEED = 32'h1234; START = 1'b1;
    @(posedge ACLK); #1 START = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      chk("len0_ignored", {BUSY, TVALID, PKTS_SENT}, {1'b0, 1'b0, 16'd2});
    end

    for (int i = 0; i < 6; i++) begin
      ready_pct = (i % 2 == 0) ? 50 : 100;
      rl = 16'($urandom_range(40, 1));
      rc = 16'($urandom_range(3, 1));
      rg = 8'($urandom_range(4, 0));
      start_run(rl, rc, rg, 8'($urandom_range(255, 0)),
                (i == 0) ? 32'hFFFF_FFFA : $urandom, int'(rc), 0);
      wait_idle(int'(rc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
